// File: rtl/wb_shared_bus_b3.sv
// Wishbone B3 shared bus: round-robin grant locked for CYC, mask/base decode, registered unmapped ERR; WB_SHARED_BUS_TIMEOUT_EN adds a stalled-slave timeout.
// Latency: grant 1 cycle, slave responses 0 cycles, unmapped ERR 1 cycle; backpressure: a silent slave holds the bus (until timeout when enabled).
module wb_shared_bus_b3 #(
  parameter int MASTERS = 3,
  parameter int SLAVES  = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter logic [SLAVES*ADDR_W-1:0] SLAVE_BASE = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [SLAVES*ADDR_W-1:0] SLAVE_MASK = {3{32'hF000_0000}},
  parameter int TIMEOUT = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [MASTERS-1:0]          m_cyc_i,
  input  logic [MASTERS-1:0]          m_stb_i,
  input  logic [MASTERS-1:0]          m_we_i,
  input  logic [MASTERS*ADDR_W-1:0]   m_adr_i,
  input  logic [MASTERS*DATA_W-1:0]   m_dat_i,
  input  logic [MASTERS*DATA_W/8-1:0] m_sel_i,
  input  logic [MASTERS*3-1:0]        m_cti_i,
  output logic [DATA_W-1:0]           m_dat_o,
  output logic [MASTERS-1:0]          m_ack_o,
  output logic [MASTERS-1:0]          m_err_o,
  output logic [MASTERS-1:0]          m_rty_o,
  output logic [SLAVES-1:0]           s_cyc_o,
  output logic [SLAVES-1:0]           s_stb_o,
  output logic                        s_we_o,
  output logic [ADDR_W-1:0]           s_adr_o,
  output logic [DATA_W-1:0]           s_dat_o,
  output logic [DATA_W/8-1:0]         s_sel_o,
  output logic [2:0]                  s_cti_o,
  input  logic [SLAVES*DATA_W-1:0]    s_dat_i,
  input  logic [SLAVES-1:0]           s_ack_i,
  input  logic [SLAVES-1:0]           s_err_i,
  input  logic [SLAVES-1:0]           s_rty_i,
  output logic [MASTERS-1:0]          gnt_o
);
  localparam int SEL_W  = DATA_W / 8;
  localparam int MIDX_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  typedef enum logic {IDLE, OWNED} state_e;

  state_e            state_q, state_d;
  logic [MIDX_W-1:0] owner_q, owner_d;
  logic [MIDX_W-1:0] last_q, last_d;
  logic              dec_err_q, dec_err_d;

  logic              owned, live;
  logic              own_cyc, own_stb, own_we;
  logic [ADDR_W-1:0] own_adr;
  logic [DATA_W-1:0] own_dat;
  logic [SEL_W-1:0]  own_sel;
  logic [2:0]        own_cti;
  logic [SLAVES-1:0] sel_oh;
  logic              sel_vld;
  logic              sl_ack, sl_err, sl_rty;
  logic [DATA_W-1:0] sl_dat;
  logic              any_rsp;
  logic              to_hit;

  // First requester strictly after 'last', wrapping; 'last' itself has lowest priority.
  function automatic logic [MIDX_W-1:0] rr_pick(input logic [MASTERS-1:0] req,
                                                input logic [MIDX_W-1:0]  last);
    logic [MIDX_W-1:0] pick;
    logic [MIDX_W-1:0] cand;
    pick = '0;
    for (int k = MASTERS; k >= 1; k--) begin
      cand = MIDX_W'((int'(last) + k) % MASTERS);
      if (req[cand]) pick = cand;
    end
    return pick;
  endfunction

  assign owned = (state_q == OWNED);
  assign live  = owned && own_cyc;

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    own_cti = '0;
    for (int m = 0; m < MASTERS; m++) begin
      if (owner_q == MIDX_W'(m)) begin
        own_cyc = m_cyc_i[m];
        own_stb = m_stb_i[m];
        own_we  = m_we_i[m];
        own_adr = m_adr_i[m*ADDR_W +: ADDR_W];
        own_dat = m_dat_i[m*DATA_W +: DATA_W];
        own_sel = m_sel_i[m*SEL_W +: SEL_W];
        own_cti = m_cti_i[m*3 +: 3];
      end
    end
  end

  // Lowest-index matching window wins when windows overlap.
  always_comb begin
    sel_oh  = '0;
    sel_vld = 1'b0;
    for (int s = 0; s < SLAVES; s++) begin
      if (!sel_vld &&
          ((own_adr & SLAVE_MASK[s*ADDR_W +: ADDR_W]) == SLAVE_BASE[s*ADDR_W +: ADDR_W])) begin
        sel_oh[s] = 1'b1;
        sel_vld   = 1'b1;
      end
    end
  end

  always_comb begin
    sl_dat = '0;
    sl_ack = 1'b0;
    sl_err = 1'b0;
    sl_rty = 1'b0;
    for (int s = 0; s < SLAVES; s++) begin
      if (sel_oh[s]) begin
        sl_dat = s_dat_i[s*DATA_W +: DATA_W];
        sl_ack = s_ack_i[s];
        sl_err = s_err_i[s];
        sl_rty = s_rty_i[s];
      end
    end
  end

  assign any_rsp = sl_ack | sl_err | sl_rty | dec_err_q;

  assign s_cyc_o = live ? sel_oh : '0;
  assign s_stb_o = (live && own_stb && !to_hit) ? sel_oh : '0;
  assign s_we_o  = owned ? own_we  : 1'b0;
  assign s_adr_o = owned ? own_adr : '0;
  assign s_dat_o = owned ? own_dat : '0;
  assign s_sel_o = owned ? own_sel : '0;
  assign s_cti_o = owned ? own_cti : '0;
  assign m_dat_o = owned ? sl_dat  : '0;

  always_comb begin
    gnt_o   = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    for (int m = 0; m < MASTERS; m++) begin
      if (owned && (owner_q == MIDX_W'(m))) begin
        gnt_o[m]   = 1'b1;
        m_ack_o[m] = sl_ack;
        m_err_o[m] = sl_err | dec_err_q | to_hit;
        m_rty_o[m] = sl_rty;
      end
    end
  end

  // Self-clearing after one cycle, so a held unmapped strobe errors every other cycle.
  assign dec_err_d = live && own_stb && !sel_vld && !dec_err_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          owner_d = rr_pick(m_cyc_i, last_q);
          last_d  = owner_d;
          state_d = OWNED;
        end
      end
      OWNED: begin
        if (!own_cyc) begin
          if (|m_cyc_i) begin
            owner_d = rr_pick(m_cyc_i, owner_q);
            last_d  = owner_d;
          end else begin
            last_d  = owner_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      last_q    <= MIDX_W'(MASTERS - 1);
      dec_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      dec_err_q <= dec_err_d;
    end
  end

`ifdef WB_SHARED_BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_q, to_d;

  assign to_hit = live && own_stb && (to_q == TO_W'(TIMEOUT));

  always_comb begin
    to_d = '0;
    if (live && own_stb && !any_rsp && !to_hit) to_d = to_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) to_q <= '0;
    else          to_q <= to_d;
  end
`else
  // No timeout hardware; the constant-false term keeps TIMEOUT referenced.
  assign to_hit = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_wb_shared_bus_b3.sv
// Directed bench for wb_shared_bus_b3: reset, round-robin, decode, unmapped ERR, lock, timeout.
module tb_wb_shared_bus_b3;
  localparam int M  = 3;
  localparam int S  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic [M-1:0]      m_cyc_i, m_stb_i, m_we_i;
  logic [M*AW-1:0]   m_adr_i;
  logic [M*DW-1:0]   m_dat_i;
  logic [M*SW-1:0]   m_sel_i;
  logic [M*3-1:0]    m_cti_i;
  logic [DW-1:0]     m_dat_o;
  logic [M-1:0]      m_ack_o, m_err_o, m_rty_o;
  logic [S-1:0]      s_cyc_o, s_stb_o;
  logic              s_we_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [SW-1:0]     s_sel_o;
  logic [2:0]        s_cti_o;
  logic [S*DW-1:0]   s_dat_i;
  logic [S-1:0]      s_ack_i, s_err_i, s_rty_i;
  logic [M-1:0]      gnt_o;
  logic              ack_en;

  int checks   = 0;
  int failures = 0;

  wb_shared_bus_b3 #(.MASTERS(M), .SLAVES(S), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i),
    .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_cti_i(m_cti_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .gnt_o(gnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Slaves answer in the strobed cycle when enabled; fixed read data per slave.
  assign s_ack_i = ack_en ? s_stb_o : '0;
  assign s_err_i = '0;
  assign s_rty_i = '0;
  assign s_dat_i = {32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_AAAA};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                       input logic [SW-1:0] sel, input logic [2:0] cti);
    m_cyc_i[m]          = cyc;
    m_stb_i[m]          = stb;
    m_we_i[m]           = we;
    m_adr_i[m*AW +: AW] = adr;
    m_dat_i[m*DW +: DW] = dat;
    m_sel_i[m*SW +: SW] = sel;
    m_cti_i[m*3 +: 3]   = cti;
  endtask

  initial begin
    int errs;
    rst_n_i = 1'b0;
    ack_en  = 1'b0;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_cti_i = '0;
    #2;
    chk("rst_gnt", 64'(gnt_o), 64'h0);
    chk("rst_s_cyc", 64'(s_cyc_o), 64'h0);
    chk("rst_m_dat", 64'(m_dat_o), 64'h0);
    tick();
    rst_n_i = 1'b1;
    tick();

    // Reset mid-transfer while master 1 strobes RAM
    set_m(1, 1, 1, 0, 32'h1000_0000, 32'h0, 4'hF, 3'b000);
    #1;
    chk("pre_grant_gnt", 64'(gnt_o), 64'h0);
    tick();
    chk("m1_gnt", 64'(gnt_o), 64'b010);
    chk("m1_s_stb", 64'(s_stb_o), 64'b010);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("async_rst_gnt", 64'(gnt_o), 64'h0);
    chk("async_rst_s_stb", 64'(s_stb_o), 64'h0);
    chk("async_rst_s_adr", 64'(s_adr_o), 64'h0);
    chk("async_rst_m_dat", 64'(m_dat_o), 64'h0);
    set_m(0, 1, 0, 0, 32'h0000_0010, 32'h0, 4'hF, 3'b000);
    set_m(1, 1, 0, 0, 32'h1000_0020, 32'h0, 4'hF, 3'b000);
    set_m(2, 1, 0, 0, 32'h2000_0030, 32'h0, 4'hF, 3'b000);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    tick();
    chk("post_rst_prio_m0", 64'(gnt_o), 64'b001);

    // Round-robin: each master drops CYC for one cycle after its ACK
    m_stb_i = 3'b111;
    ack_en  = 1'b1;
    #1;
    chk("rr0_ack", 64'(m_ack_o), 64'b001);
    chk("rr0_dat", 64'(m_dat_o), 64'h0000_AAAA);
    tick();
    set_m(0, 0, 0, 0, 32'h0000_0010, 32'h0, 4'hF, 3'b000);
    #1;
    chk("rr0_release_gnt", 64'(gnt_o), 64'b001);
    chk("rr0_release_s_cyc", 64'(s_cyc_o), 64'h0);
    tick();
    set_m(0, 1, 1, 0, 32'h0000_0010, 32'h0, 4'hF, 3'b000);
    #1;
    chk("rr1_gnt", 64'(gnt_o), 64'b010);
    chk("rr1_ack", 64'(m_ack_o), 64'b010);
    chk("rr1_dat", 64'(m_dat_o), 64'hDEAD_BEEF);
    tick();
    set_m(1, 0, 0, 0, 32'h1000_0020, 32'h0, 4'hF, 3'b000);
    chk("rr1_onehot", 64'($onehot(gnt_o)), 64'h1);
    tick();
    set_m(1, 1, 1, 0, 32'h1000_0020, 32'h0, 4'hF, 3'b000);
    #1;
    chk("rr2_gnt", 64'(gnt_o), 64'b100);
    chk("rr2_s_stb", 64'(s_stb_o), 64'b100);
    chk("rr2_dat", 64'(m_dat_o), 64'h2222_2222);
    tick();
    set_m(2, 0, 0, 0, 32'h2000_0030, 32'h0, 4'hF, 3'b000);
    tick();
    set_m(2, 1, 1, 0, 32'h2000_0030, 32'h0, 4'hF, 3'b000);
    #1;
    chk("rr3_gnt_wrap", 64'(gnt_o), 64'b001);
    tick();
    m_cyc_i = '0; m_stb_i = '0;
    tick();
    chk("rr_idle_gnt", 64'(gnt_o), 64'h0);

    // Decode: master 0 reads RAM, then writes ROM
    set_m(0, 1, 1, 0, 32'h1000_0040, 32'h0, 4'hF, 3'b000);
    ack_en = 1'b0;
    tick();
    chk("dec_gnt", 64'(gnt_o), 64'b001);
    chk("dec_s_stb", 64'(s_stb_o), 64'b010);
    chk("dec_s_cyc", 64'(s_cyc_o), 64'b010);
    chk("dec_s_adr", 64'(s_adr_o), 64'h1000_0040);
    chk("dec_stall_ack", 64'(m_ack_o), 64'h0);
    ack_en = 1'b1;
    #1;
    chk("dec_ack_same_cycle", 64'(m_ack_o), 64'b001);
    chk("dec_rdata", 64'(m_dat_o), 64'hDEAD_BEEF);
    tick();
    set_m(0, 1, 1, 1, 32'h0000_0100, 32'h1234_5678, 4'b0011, 3'b111);
    ack_en = 1'b0;
    #1;
    chk("wr_s_stb", 64'(s_stb_o), 64'b001);
    chk("wr_s_we", 64'(s_we_o), 64'h1);
    chk("wr_s_dat", 64'(s_dat_o), 64'h1234_5678);
    chk("wr_s_sel", 64'(s_sel_o), 64'h3);
    chk("wr_s_cti", 64'(s_cti_o), 64'h7);
    tick();
    set_m(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000);
    tick();

    // Unmapped: master 2 holds STB at 0x3000_0000
    set_m(2, 1, 1, 0, 32'h3000_0000, 32'h0, 4'hF, 3'b000);
    tick();
    chk("unm_gnt", 64'(gnt_o), 64'b100);
    chk("unm_s_stb", 64'(s_stb_o), 64'h0);
    chk("unm_err_first", 64'(m_err_o), 64'h0);
    chk("unm_m_dat", 64'(m_dat_o), 64'h0);
    tick();
    chk("unm_err_next", 64'(m_err_o), 64'b100);
    tick();
    chk("unm_err_gap", 64'(m_err_o), 64'h0);
    tick();
    chk("unm_err_again", 64'(m_err_o), 64'b100);
    tick();
    set_m(2, 0, 0, 0, 32'h3000_0000, 32'h0, 4'hF, 3'b000);
    #1;
    chk("unm_err_release", 64'(m_err_o), 64'h0);
    tick();

    // Lock: master 1 holds CYC for 4 strobes while master 0 requests
    set_m(1, 1, 1, 0, 32'h1000_0000, 32'h0, 4'hF, 3'b000);
    ack_en = 1'b1;
    tick();
    chk("lock_gnt_m1", 64'(gnt_o), 64'b010);
    set_m(0, 1, 1, 0, 32'h0000_0000, 32'h0, 4'hF, 3'b000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lock_held_gnt", 64'(gnt_o), 64'b010);
      chk("lock_held_ack", 64'(m_ack_o), 64'b010);
    end
    tick();
    set_m(1, 0, 0, 0, 32'h1000_0000, 32'h0, 4'hF, 3'b000);
    #1;
    chk("lock_release_gnt", 64'(gnt_o), 64'b010);
    chk("lock_release_ack", 64'(m_ack_o), 64'h0);
    tick();
    chk("lock_handover_gnt", 64'(gnt_o), 64'b001);
    chk("lock_handover_ack", 64'(m_ack_o), 64'b001);
    tick();
    set_m(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000);
    tick();

    // Silent slave
    set_m(0, 1, 1, 0, 32'h2000_0000, 32'h0, 4'hF, 3'b000);
    ack_en = 1'b0;
    tick();
`ifdef WB_SHARED_BUS_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      chk("to_wait_err", 64'(m_err_o), 64'h0);
      chk("to_wait_s_stb", 64'(s_stb_o), 64'b100);
      tick();
    end
    chk("to_fire_err", 64'(m_err_o), 64'b001);
    chk("to_fire_s_stb", 64'(s_stb_o), 64'h0);
    tick();
    chk("to_after_err", 64'(m_err_o), 64'h0);
    chk("to_after_s_stb", 64'(s_stb_o), 64'b100);
`else
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      if (m_err_o != '0) errs++;
      tick();
    end
    chk("no_to_err_count", 64'(errs), 64'h0);
    chk("no_to_gnt", 64'(gnt_o), 64'b001);
    chk("no_to_s_stb", 64'(s_stb_o), 64'b100);
`endif
    set_m(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000);
    tick();
    tick();
    chk("final_idle_gnt", 64'(gnt_o), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
